// File: rtl/gmac_tx_feeder.sv
// gmac_tx_feeder: byte buffer that collects payload bytes and hands them to a
// MAC TX client channel as fixed-length frames. A frame is requested once a
// full payload is buffered. After the grant the frame streams out
// back-to-back, and then a minimum inter-frame gap is enforced.

module gmac_tx_feeder #(
  parameter int PKT_LEN    = 1024,
  parameter int FIFO_DEPTH = 2048,
  parameter int IFG_CYCLES = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WR_EN,
  input  logic [7:0]  WR_DATA,
  output logic        FULL,
  output logic        ReqOut,
  input  logic        ReqConfirm,
  output logic        ValOut,
  output logic        SoFOut,
  output logic        EoFOut,
  output logic [7:0]  DataOut,
  output logic [15:0] FRAME_CNT,
  output logic [15:0] DROP_CNT
);

  // Pointer width addresses the buffer; the level needs one extra bit so that
  // "completely full" can be told apart from "empty".
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PKT_C   = CW'(PKT_LEN);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // The IDLE cycle that evaluates the next request is itself one idle cycle.
  // GAP therefore holds for IFG_CYCLES-1 cycles, which gives exactly
  // IFG_CYCLES idle cycles between EoFOut and the next ReqOut when enough data
  // is already waiting. The value loaded here is the GAP cycle count minus one.
  localparam logic [7:0] GAP_LOAD_C = (IFG_CYCLES > 1) ? 8'(IFG_CYCLES - 2) : 8'd0;

  // Parameter sanity checks at elaboration time.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gmac_tx_feeder: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PKT_LEN < 1 || PKT_LEN > FIFO_DEPTH) begin : g_bad_pkt
    $error("gmac_tx_feeder: PKT_LEN must be in 1..FIFO_DEPTH");
  end
  if (IFG_CYCLES < 0 || IFG_CYCLES > 255) begin : g_bad_ifg
    $error("gmac_tx_feeder: IFG_CYCLES must be in 0..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SEND,
    GAP
  } state_e;

  state_e          state_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   level_q, level_d;

  logic [CW-1:0]   byte_cnt_q;  // index (1-based) of the byte currently on DataOut
  logic [7:0]      gap_q;

  logic            req_q;
  logic            val_q;
  logic            sof_q;
  logic            eof_q;
  logic [7:0]      data_q;
  logic [15:0]     frame_cnt_q;
  logic [15:0]     drop_cnt_q;

  logic            full;
  logic            wr_ok;
  logic            rd_en;
  logic            last_byte;

  // Buffer status and the push/pop strobes.
  assign full      = (level_q == DEPTH_C);
  assign wr_ok     = WR_EN & ~full;
  assign last_byte = (byte_cnt_q == PKT_C);
  // A byte is popped on the grant edge (first byte) and on every SEND edge
  // except the one that retires the final byte.
  assign rd_en     = ((state_q == REQ) & ReqConfirm) |
                     ((state_q == SEND) & ~last_byte);

  // Next-state values for the buffer pointers and the level counter.
  // NOTE: every always_comb output gets a default at the top. A path that
  // leaves a variable unassigned would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_ok, rd_en})
      2'b10:   level_d = level_q + ONE_C;
      2'b01:   level_d = level_q - ONE_C;
      default: level_d = level_q;
    endcase
  end

  // Buffer pointers and level. Reset empties the buffer.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Byte storage. A byte offered while RST is high is not stored.
  // NOTE: the storage array is deliberately not reset. The pointers define
  // what is valid, and a reset port on the array would block RAM inference.
  always_ff @(posedge CLK) begin
    if (wr_ok && !RST) begin
      mem_q[wr_ptr_q] <= WR_DATA;
    end
  end

  // Frame FSM with registered outputs, frame counter and drop counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      gap_q       <= '0;
      req_q       <= 1'b0;
      val_q       <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      data_q      <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      // A write is dropped whenever the buffer is full, even if a pop frees
      // a slot on the same edge.
      if (WR_EN && full && drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end

      unique case (state_q)
        IDLE: begin
          if (level_q >= PKT_C) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end

        REQ: begin
          // Wait for the grant with no timeout. The first byte is presented
          // on the grant edge.
          if (ReqConfirm) begin
            state_q    <= SEND;
            req_q      <= 1'b0;
            val_q      <= 1'b1;
            sof_q      <= 1'b1;
            eof_q      <= (PKT_C == ONE_C);
            data_q     <= mem_q[rd_ptr_q];
            byte_cnt_q <= ONE_C;
          end
        end

        SEND: begin
          if (last_byte) begin
            val_q       <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            data_q      <= '0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (IFG_CYCLES > 1) begin
              state_q <= GAP;
              gap_q   <= GAP_LOAD_C;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            sof_q      <= 1'b0;
            eof_q      <= ((byte_cnt_q + ONE_C) == PKT_C);
            data_q     <= mem_q[rd_ptr_q];
            byte_cnt_q <= byte_cnt_q + ONE_C;
          end
        end

        GAP: begin
          if (gap_q == 8'd0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign FULL      = full;
  assign ReqOut    = req_q;
  assign ValOut    = val_q;
  assign SoFOut    = sof_q;
  assign EoFOut    = eof_q;
  assign DataOut   = data_q;
  assign FRAME_CNT = frame_cnt_q;
  assign DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_gmac_tx_feeder.sv
// Bench for gmac_tx_feeder. Instance A uses PKT_LEN=4, FIFO_DEPTH=8 and
// IFG_CYCLES=3. Instance B uses PKT_LEN=3, FIFO_DEPTH=8 and IFG_CYCLES=0.
// Accepted writes are pushed to a per-instance scoreboard queue, and each
// byte the DUT emits is popped from that queue and compared.

module tb_gmac_tx_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A ----------------
  logic        a_rst, a_wr_en, a_full, a_req, a_conf, a_val, a_sof, a_eof;
  logic [7:0]  a_wr_data, a_data;
  logic [15:0] a_fcnt, a_dcnt;

  gmac_tx_feeder #(.PKT_LEN(4), .FIFO_DEPTH(8), .IFG_CYCLES(3)) u_a (
    .CLK(clk), .RST(a_rst), .WR_EN(a_wr_en), .WR_DATA(a_wr_data), .FULL(a_full),
    .ReqOut(a_req), .ReqConfirm(a_conf), .ValOut(a_val), .SoFOut(a_sof),
    .EoFOut(a_eof), .DataOut(a_data), .FRAME_CNT(a_fcnt), .DROP_CNT(a_dcnt)
  );

  // ---------------- instance B ----------------
  logic        b_rst, b_wr_en, b_full, b_req, b_conf, b_val, b_sof, b_eof;
  logic [7:0]  b_wr_data, b_data;
  logic [15:0] b_fcnt, b_dcnt;

  gmac_tx_feeder #(.PKT_LEN(3), .FIFO_DEPTH(8), .IFG_CYCLES(0)) u_b (
    .CLK(clk), .RST(b_rst), .WR_EN(b_wr_en), .WR_DATA(b_wr_data), .FULL(b_full),
    .ReqOut(b_req), .ReqConfirm(b_conf), .ValOut(b_val), .SoFOut(b_sof),
    .EoFOut(b_eof), .DataOut(b_data), .FRAME_CNT(b_fcnt), .DROP_CNT(b_dcnt)
  );

  // Scoreboard and reference-model state. Only the monitors write these.
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  logic [7:0] a_exp, b_exp;
  int a_lvl = 0, a_pos = 0, a_frames = 0, a_eof_cyc = 0, a_gap = -1, a_req_cnt = 0;
  int b_lvl = 0, b_pos = 0, b_frames = 0;
  logic a_req_prev = 1'b0;

  // Monitor A. It runs on the falling edge, so it sees this cycle's outputs
  // and the write that the next rising edge will take.
  always @(negedge clk) begin
    if (a_val) begin
      if (a_q.size() == 0) begin
        check("a_unexpected_byte", a_val, 0);
      end else begin
        a_exp = a_q.pop_front();
        check("a_data", a_data, a_exp);
      end
      check("a_sof", a_sof, (a_pos == 0));
      check("a_eof", a_eof, (a_pos == 3));
      if (a_pos == 3) begin
        a_pos = 0;
        a_frames++;
        a_eof_cyc = cyc;
      end else begin
        a_pos++;
      end
      a_lvl--;
    end else begin
      check("a_idle_zero", {a_sof, a_eof, a_data}, 0);
      if (a_pos != 0) check("a_gap_in_frame", a_val, 1);
    end
    check("a_full", a_full, (a_lvl == 8));
    if (a_req && !a_req_prev) a_gap = cyc - a_eof_cyc - 1;
    a_req_prev = a_req;
    if (a_req) a_req_cnt++;
    if (a_rst) begin
      a_q.delete();
      a_lvl = 0;
      a_pos = 0;
      a_frames = 0;
    end else if (a_wr_en && a_lvl < 8) begin
      a_q.push_back(a_wr_data);
      a_lvl++;
    end
  end

  // Monitor B, the same model for the PKT_LEN=3 instance.
  always @(negedge clk) begin
    if (b_val) begin
      if (b_q.size() == 0) begin
        check("b_unexpected_byte", b_val, 0);
      end else begin
        b_exp = b_q.pop_front();
        check("b_data", b_data, b_exp);
      end
      check("b_sof", b_sof, (b_pos == 0));
      check("b_eof", b_eof, (b_pos == 2));
      if (b_pos == 2) begin
        b_pos = 0;
        b_frames++;
      end else begin
        b_pos++;
      end
      b_lvl--;
    end else begin
      check("b_idle_zero", {b_sof, b_eof, b_data}, 0);
      if (b_pos != 0) check("b_gap_in_frame", b_val, 1);
    end
    check("b_full", b_full, (b_lvl == 8));
    if (b_rst) begin
      b_q.delete();
      b_lvl = 0;
      b_pos = 0;
      b_frames = 0;
    end else if (b_wr_en && b_lvl < 8) begin
      b_q.push_back(b_wr_data);
      b_lvl++;
    end
  end

  task automatic a_wr(input logic [7:0] b);
    a_wr_en   = 1'b1;
    a_wr_data = b;
    tick;
    a_wr_en   = 1'b0;
  endtask

  task automatic wait_a(input int n, input int budget);
    for (int i = 0; i < budget && a_frames < n; i++) tick;
    check("a_frame_wait", a_frames, n);
  endtask

  task automatic wait_b(input int n, input int budget);
    for (int i = 0; i < budget && b_frames < n; i++) tick;
    check("b_frame_wait", b_frames, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int k;
    int guard;

    a_rst = 1'b1; a_wr_en = 1'b0; a_wr_data = '0; a_conf = 1'b0;
    b_rst = 1'b1; b_wr_en = 1'b0; b_wr_data = '0; b_conf = 1'b1;
    repeat (3) tick;
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick;

    // Reset state.
    check("a_rst_outs", {a_req, a_val, a_sof, a_eof, a_data}, 0);
    check("a_rst_cnts", {a_fcnt, a_dcnt}, 0);
    check("a_rst_full", a_full, 0);
    check("b_rst_outs", {b_req, b_val, b_sof, b_eof, b_data}, 0);
    check("b_rst_cnts", {b_fcnt, b_dcnt}, 0);

    // Basic frame, grant three cycles after the request.
    for (int i = 1; i <= 4; i++) a_wr(8'(i));
    n0 = a_req_cnt;
    for (int i = 0; i < 20 && !a_req; i++) tick;
    check("a_req_seen", a_req, 1);
    tick;
    tick;
    a_conf = 1'b1;
    tick;
    a_conf = 1'b0;
    check("a_first_val", a_val, 1);
    check("a_first_sof", a_sof, 1);
    check("a_first_data", a_data, 8'h01);
    check("a_req_dropped", a_req, 0);
    check("a_req_hold", a_req_cnt - n0, 3);
    wait_a(1, 20);
    check("a_fcnt_1", a_fcnt, 1);

    // A grant while idle below threshold is ignored.
    repeat (5) tick;
    a_wr(8'h10);
    a_wr(8'h11);
    a_conf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("a_idle_conf_req", a_req, 0);
      check("a_idle_conf_val", a_val, 0);
    end

    // Grant tied high with eight bytes buffered. Check the inter-frame gap.
    for (int i = 8'h12; i <= 8'h17; i++) a_wr(8'(i));
    wait_a(3, 60);
    check("a_ifg", a_gap, 3);
    check("a_fcnt_3", a_fcnt, 3);
    a_conf = 1'b0;

    // Overflow: ten writes and no reads.
    repeat (5) tick;
    for (int i = 8'h20; i <= 8'h29; i++) a_wr(8'(i));
    check("a_full_set", a_full, 1);
    check("a_drop_2", a_dcnt, 2);
    a_conf = 1'b1;
    wait_a(5, 60);
    check("a_fcnt_5", a_fcnt, 5);
    check("a_full_clr", a_full, 0);
    check("a_drop_hold", a_dcnt, 2);

    // Reset asserted during byte 2 of a frame, with a write in the same cycle.
    repeat (5) tick;
    for (int i = 8'h30; i <= 8'h33; i++) a_wr(8'(i));
    for (int i = 0; i < 30 && !a_sof; i++) tick;
    check("a_sof_seen", a_sof, 1);
    tick;
    a_rst = 1'b1;
    a_wr_en = 1'b1;
    a_wr_data = 8'hEE;
    tick;
    a_rst = 1'b0;
    a_wr_en = 1'b0;
    a_conf = 1'b0;
    check("a_mid_rst_outs", {a_req, a_val, a_sof, a_eof, a_data}, 0);
    check("a_mid_rst_cnts", {a_fcnt, a_dcnt}, 0);
    check("a_mid_rst_full", a_full, 0);
    a_wr(8'h40);
    a_wr(8'h41);
    a_wr(8'h42);
    repeat (3) tick;
    check("a_lvl_after_rst", a_req, 0);
    a_conf = 1'b1;
    a_wr(8'h43);
    wait_a(1, 30);
    check("a_fcnt_after_rst", a_fcnt, 1);
    check("a_q_empty", a_q.size(), 0);
    a_conf = 1'b0;

    // Instance B: continuous writes, throttled only by FULL, across pointer wrap.
    k = 0;
    guard = 0;
    while (k < 60 && guard < 2000) begin
      if (!b_full) begin
        b_wr_en = 1'b1;
        b_wr_data = 8'(k * 37 + 5);
        k++;
      end else begin
        b_wr_en = 1'b0;
      end
      tick;
      guard++;
    end
    b_wr_en = 1'b0;
    check("b_writes_done", k, 60);
    wait_b(20, 400);
    check("b_fcnt_20", b_fcnt, 20);
    check("b_drop_0", b_dcnt, 0);
    check("b_q_empty", b_q.size(), 0);

    repeat (3) tick;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
